// File: rtl/uart_rx_deframer.sv
// Recovers SYNC/LEN/PAYLOAD/CSUM packets from a UART byte stream and replays checksum-verified payloads.
// Latency: first payload byte is valid the cycle after the checksum byte; then 1 byte/cycle.
// Backpressure: pkt_valid/pkt_data/pkt_last hold while !pkt_ready; rx bytes arriving while draining are dropped and counted.
`timescale 1ns/1ps
module uart_rx_deframer #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 20840
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic [7:0] ovr_cnt,
    output logic       busy
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CSUM    = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    logic [2:0]    state;
    logic [7:0]    len;
    logic [7:0]    csum;
    logic [IW-1:0] idx;
    logic [IW-1:0] rd_idx;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    buf_mem [2**AW];

    logic       in_pkt;
    logic       timeout;
    logic       drain;
    logic       xfer;
    logic       rd_last;
    logic [7:0] len_m1;

    assign len_m1  = len - 8'd1;
    assign in_pkt  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    // A byte landing in the expiry cycle takes priority over the timeout.
    assign timeout = in_pkt && !rx_valid && (idle_cnt == TO_LAST);
    assign drain   = (state == S_DRAIN);
    assign xfer    = drain && pkt_ready;
    assign rd_last = (8'(rd_idx) == len_m1);

    assign pkt_valid = drain;
    assign pkt_data  = drain ? buf_mem[rd_idx[AW-1:0]] : 8'h00;
    assign pkt_last  = drain && rd_last;
    assign busy      = (state != S_IDLE);

    // Payload storage needs no reset; only bytes written this packet are ever read.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && rx_valid) begin
            buf_mem[idx[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= S_IDLE;
            len      <= 8'h00;
            csum     <= 8'h00;
            idx      <= '0;
            rd_idx   <= '0;
            idle_cnt <= '0;
            pkt_err  <= 1'b0;
            err_code <= 2'b00;
            ovr_cnt  <= 8'h00;
        end else begin
            pkt_err  <= 1'b0;
            idle_cnt <= (in_pkt && !rx_valid) ? idle_cnt + 1'b1 : '0;
            if (drain && rx_valid && ovr_cnt != 8'hFF) begin
                ovr_cnt <= ovr_cnt + 8'd1;
            end
            if (timeout) begin
                pkt_err  <= 1'b1;
                err_code <= 2'b11;
                state    <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) state <= S_LEN;
                    end
                    S_LEN: begin
                        if (rx_valid) begin
                            if (rx_data == 8'h00 || int'(rx_data) > MAX_LEN) begin
                                pkt_err  <= 1'b1;
                                err_code <= 2'b01;
                                state    <= S_IDLE;
                            end else begin
                                len   <= rx_data;
                                csum  <= rx_data;
                                idx   <= '0;
                                state <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_valid) begin
                            csum <= csum ^ rx_data;
                            idx  <= idx + 1'b1;
                            if (8'(idx) == len_m1) state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (rx_valid) begin
                            if (rx_data == csum) begin
                                rd_idx <= '0;
                                state  <= S_DRAIN;
                            end else begin
                                pkt_err  <= 1'b1;
                                err_code <= 2'b10;
                                state    <= S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (xfer) begin
                            rd_idx <= rd_idx + 1'b1;
                            if (rd_last) state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
